relm_custom_issue: RTL and testbench

Operand-capture and result-return stage placed directly upstream of `relm_custom` in the ReLM pipeline. It registers one custom-op request from the core and holds the operands stable at the `relm_custom` inputs for a fixed multicycle window of LAT cycles. It then samples `relm_custom`'s `a_out`/`cb_out` and presents the result to writeback through a valid/ready handshake. This lets the custom path be timed as a multicycle path without stalling unrelated pipeline logic.

---
 rtl/relm_custom_issue_pkg.sv | 17 +
 rtl/relm_custom_issue_if.sv | 29 ++
 rtl/relm_custom_issue.sv | 127 ++++++++++++
 tb/tb_relm_custom_issue.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/relm_custom_issue_pkg.sv
// Shared types and constants for the relm_custom operand-capture / result-return stage.
package relm_custom_issue_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int CNT_W = 4;

    // The countdown register is CNT_W bits, so the multicycle window is bounded by its range.
    function automatic bit lat_legal(input int lat);
        return (lat >= 1) && (lat <= 15);
    endfunction

endpackage

// File: rtl/relm_custom_issue_if.sv
// Request/response bus between the core, the issue stage and writeback.
interface relm_custom_issue_if #(
    parameter int WD  = 32,
    parameter int WOP = 5,
    parameter int WC  = 0
);
    logic                 req_valid;
    logic                 req_ready;
    logic [WOP-1:0]       op_in;
    logic [WD-1:0]        a_in;
    logic [WC+WD-1:0]     cb_in;
    logic [WD-1:0]        x_in;
    logic [WD-1:0]        xb_in;
    logic                 opb_in;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [WD-1:0]        a_out;
    logic [WC+WD-1:0]     cb_out;

    modport master (
        output req_valid, op_in, a_in, cb_in, x_in, xb_in, opb_in, rsp_ready,
        input  req_ready, rsp_valid, a_out, cb_out
    );

    modport slave (
        input  req_valid, op_in, a_in, cb_in, x_in, xb_in, opb_in, rsp_ready,
        output req_ready, rsp_valid, a_out, cb_out
    );
endinterface

// File: rtl/relm_custom_issue.sv
// Holds one custom op's operands stable for LAT cycles at the relm_custom inputs,
// then samples its result and returns it to writeback over a valid/ready handshake.
module relm_custom_issue
    import relm_custom_issue_pkg::*;
#(
    parameter int WD  = 32,
    parameter int WOP = 5,
    parameter int WC  = 0,
    parameter int LAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    relm_custom_issue_if.slave    bus,
    input  logic                  abort,
    output logic [WOP-1:0]        cu_op,
    output logic [WD-1:0]         cu_a,
    output logic [WC+WD-1:0]      cu_cb,
    output logic [WD-1:0]         cu_x,
    output logic [WD-1:0]         cu_xb,
    output logic                  cu_opb,
    input  logic [WD-1:0]         cu_a_res,
    input  logic [WC+WD-1:0]      cu_cb_res,
    output logic                  busy
);

    if (!lat_legal(LAT)) begin : g_lat_illegal
        $fatal(1, "relm_custom_issue: LAT must be within 1..15");
    end

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

    state_t              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [WD-1:0]       a_out_r;
    logic [WC+WD-1:0]    cb_out_r;
    logic                rsp_valid_r;
    logic                busy_r;
    logic                req_ready_s;
    logic                accept_s;

    // Request acceptance; HOLD hands ready straight through so the next op overlaps the response.
    always_comb begin
        req_ready_s = 1'b0;
        if (rst || abort) begin
            req_ready_s = 1'b0;
        end else begin
            case (state_r)
                IDLE:    req_ready_s = 1'b1;
                WAIT:    req_ready_s = 1'b0;
                HOLD:    req_ready_s = bus.rsp_ready;
                default: req_ready_s = 1'b0;
            endcase
        end
    end

    assign accept_s      = bus.req_valid && req_ready_s;
    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.a_out     = a_out_r;
    assign bus.cb_out    = cb_out_r;
    assign busy          = busy_r;

    // Issue FSM with its multicycle countdown, operand capture and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            cu_op       <= {WOP{1'b0}};
            cu_a        <= {WD{1'b0}};
            cu_cb       <= {(WC+WD){1'b0}};
            cu_x        <= {WD{1'b0}};
            cu_xb       <= {WD{1'b0}};
            cu_opb      <= 1'b0;
            a_out_r     <= {WD{1'b0}};
            cb_out_r    <= {(WC+WD){1'b0}};
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else if (abort) begin
            // Flush: any result that would have been sampled this edge is dropped.
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else if (accept_s) begin
            cu_op       <= bus.op_in;
            cu_a        <= bus.a_in;
            cu_cb       <= bus.cb_in;
            cu_x        <= bus.x_in;
            cu_xb       <= bus.xb_in;
            cu_opb      <= bus.opb_in;
            cnt_r       <= CNT_LOAD;
            state_r     <= WAIT;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    rsp_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
                WAIT: begin
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        a_out_r     <= cu_a_res;
                        cb_out_r    <= cu_cb_res;
                        rsp_valid_r <= 1'b1;
                        state_r     <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.rsp_ready) begin
                        state_r     <= IDLE;
                        rsp_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    rsp_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_relm_custom_issue.sv
// Three issue stages (LAT = 2, 1, 5) share one randomized stimulus stream; each is checked
// cycle by cycle against a transaction-level model with an adder/xor stub standing in for relm_custom.
module tb_relm_custom_issue;

    localparam int WD  = 32;
    localparam int WOP = 5;
    localparam int WC  = 0;
    localparam int NL  = 3;

    typedef struct packed {
        logic [WOP-1:0]   op;
        logic [WD-1:0]    a;
        logic [WC+WD-1:0] cb;
        logic [WD-1:0]    x;
        logic [WD-1:0]    xb;
        logic             opb;
    } ops_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid, rsp_ready, abort, opb_in;
    logic [WOP-1:0]   op_in;
    logic [WD-1:0]    a_in, x_in, xb_in;
    logic [WC+WD-1:0] cb_in;

    logic             rv_l [NL];
    logic             rr_l [NL];
    logic             bz_l [NL];
    logic [WD-1:0]    ao_l [NL];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < NL; g++) begin : g_lane
        localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 5;

        relm_custom_issue_if #(.WD(WD), .WOP(WOP), .WC(WC)) bus ();
        logic [WOP-1:0]   cu_op;
        logic [WD-1:0]    cu_a, cu_x, cu_xb, cu_a_res;
        logic [WC+WD-1:0] cu_cb, cu_cb_res;
        logic             cu_opb, busy;

        assign bus.req_valid = req_valid;
        assign bus.op_in     = op_in;
        assign bus.a_in      = a_in;
        assign bus.cb_in     = cb_in;
        assign bus.x_in      = x_in;
        assign bus.xb_in     = xb_in;
        assign bus.opb_in    = opb_in;
        assign bus.rsp_ready = rsp_ready;

        // Stub for relm_custom: a_out = a + x, cb_out = cb ^ xb.
        assign cu_a_res  = cu_a + cu_x;
        assign cu_cb_res = cu_cb ^ cu_xb;

        assign rv_l[g] = bus.rsp_valid;
        assign rr_l[g] = bus.req_ready;
        assign bz_l[g] = busy;
        assign ao_l[g] = bus.a_out;

        relm_custom_issue #(.WD(WD), .WOP(WOP), .WC(WC), .LAT(L)) dut (
            .clk(clk), .rst(rst), .bus(bus), .abort(abort),
            .cu_op(cu_op), .cu_a(cu_a), .cu_cb(cu_cb), .cu_x(cu_x), .cu_xb(cu_xb),
            .cu_opb(cu_opb), .cu_a_res(cu_a_res), .cu_cb_res(cu_cb_res), .busy(busy)
        );

        // Model: an op in flight counts down the edges left until its result appears;
        // a held result waits for rsp_ready; operands persist until the next accepted op.
        bit               in_flight = 1'b0;
        bit               have_res  = 1'b0;
        int               edges_left = 0;
        ops_t             m_ops = '0;
        logic [WD-1:0]    m_a  = '0;
        logic [WC+WD-1:0] m_cb = '0;

        always @(negedge clk) begin : model
            bit exp_rdy;
            if (rst) begin
                check($sformatf("l%0d_rst_outs", g),
                      {bus.req_ready, bus.rsp_valid, busy, bus.a_out, bus.cb_out}, '0);
                check($sformatf("l%0d_rst_cu", g), {cu_op, cu_a, cu_cb, cu_x, cu_xb, cu_opb}, '0);
                in_flight = 1'b0;
                have_res  = 1'b0;
                m_ops = '0;
                m_a   = '0;
                m_cb  = '0;
            end else begin
                exp_rdy = !abort && ((!in_flight && !have_res) || (have_res && rsp_ready));
                check($sformatf("l%0d_req_ready", g), bus.req_ready, exp_rdy);
                check($sformatf("l%0d_rsp_valid", g), bus.rsp_valid, have_res);
                check($sformatf("l%0d_busy", g), busy, in_flight || have_res);
                check($sformatf("l%0d_a_out", g), bus.a_out, m_a);
                check($sformatf("l%0d_cb_out", g), bus.cb_out, m_cb);
                check($sformatf("l%0d_cu_operands", g), {cu_op, cu_a, cu_cb, cu_x, cu_xb, cu_opb}, m_ops);
                if (abort) begin
                    in_flight = 1'b0;
                    have_res  = 1'b0;
                end else if (in_flight) begin
                    if (edges_left == 1) begin
                        in_flight = 1'b0;
                        have_res  = 1'b1;
                        m_a  = m_ops.a + m_ops.x;
                        m_cb = m_ops.cb ^ m_ops.xb;
                    end else begin
                        edges_left--;
                    end
                end else begin
                    if (have_res && rsp_ready) have_res = 1'b0;
                    if (req_valid && exp_rdy) begin
                        in_flight  = 1'b1;
                        edges_left = L;
                        m_ops = '{op: op_in, a: a_in, cb: cb_in, x: x_in, xb: xb_in, opb: opb_in};
                    end
                end
            end
        end
    end

    task automatic rand_operands();
        op_in  = WOP'($urandom);
        a_in   = $urandom;
        cb_in  = $urandom;
        x_in   = $urandom;
        xb_in  = $urandom;
        opb_in = 1'($urandom);
    endtask

    // Single op on the LAT=2 lane: latency in edges after the accepting edge and the stub result.
    task automatic single_op(input string tag);
        int n;
        req_valid = 1'b1;
        op_in = 5'd3; a_in = 32'h1234_5678; x_in = 32'h0000_0001;
        cb_in = 32'hA5A5_0000; xb_in = 32'h0000_5A5A; opb_in = 1'b1;
        step();
        req_valid = 1'b0;
        rand_operands();
        n = 1;
        step();
        while (!rv_l[0] && n < 12) begin
            step();
            n++;
        end
        check({tag, "_latency"}, n, 2);
        check({tag, "_a_out"}, ao_l[0], 32'h1234_5679);
    endtask

    initial begin
        int resp;
        logic [WD-1:0] held_a;
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; abort = 1'b0;
        op_in = '0; a_in = '0; cb_in = '0; x_in = '0; xb_in = '0; opb_in = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        single_op("single");

        // Backpressure: result held, ready stays low, the next op goes in as rsp_ready rises.
        held_a = ao_l[0];
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rand_operands();
            step();
            check("bp_req_ready_low", rr_l[0], 1'b0);
            check("bp_a_out_stable", ao_l[0], held_a);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", rr_l[0], 1'b1);

        // Clear every lane, then stream back-to-back ops with rsp_ready held high.
        abort = 1'b1;
        step();
        abort = 1'b0;
        resp = 0;
        for (int i = 0; i < 24; i++) begin
            rand_operands();
            step();
            if (rv_l[0]) resp++;
        end
        check("b2b_responses", resp, 8);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;

        // Abort in the first WAIT cycle.
        req_valid = 1'b1;
        rand_operands();
        step();
        req_valid = 1'b0;
        abort = 1'b1;
        req_valid = 1'b1;
        #1;
        check("abort_wait_ready", rr_l[0], 1'b0);
        step();
        abort = 1'b0;
        req_valid = 1'b0;
        check("abort_wait_no_rsp", rv_l[0], 1'b0);
        check("abort_wait_idle", bz_l[0], 1'b0);

        // Abort while the result is held.
        req_valid = 1'b1;
        rand_operands();
        step();
        req_valid = 1'b0;
        repeat (2) step();
        check("abort_hold_valid", rv_l[0], 1'b1);
        abort = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        #1;
        check("abort_hold_ready", rr_l[0], 1'b0);
        step();
        abort = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        check("abort_hold_no_rsp", rv_l[0], 1'b0);
        check("abort_hold_idle", bz_l[0], 1'b0);

        // Asynchronous reset in the middle of WAIT, then a clean op.
        req_valid = 1'b1;
        rand_operands();
        step();
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_mid_wait_outs", {rr_l[0], rv_l[0], bz_l[0], ao_l[0]}, '0);
        step();
        rst = 1'b0;
        step();
        single_op("post_rst");
        rsp_ready = 1'b1;
        step();

        // Random traffic on all lanes, including request toggling while ops are in flight.
        for (int i = 0; i < 6000; i++) begin
            req_valid = ($urandom_range(0, 1) == 1);
            rsp_ready = ($urandom_range(0, 3) != 0);
            abort     = ($urandom_range(0, 31) == 0);
            rand_operands();
            step();
        end
        abort = 1'b0;
        req_valid = 1'b0;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
